// File: rtl/wb_pipe_stage_pkg.sv
// wb_pipe_stage_pkg: shared defaults and constants for the MEM->WB stage
package wb_pipe_stage_pkg;
    localparam int   DATA_W_DEF = 32;
    localparam int   ADDR_W_DEF = 5;
    localparam int   R0_ADDR    = 0;
    localparam logic RST_ACTIVE = 1'b0;
endpackage

// File: rtl/wb_pipe_stage_sanitize.sv
// wb_lane_sanitize: masks r0 writes and lower lanes that collide with a higher enabled lane
module wb_lane_sanitize
    import wb_pipe_stage_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [LANES-1:0]        i_we,
    input  logic [LANES*ADDR_W-1:0] i_waddr,
    output logic [LANES-1:0]        o_we
);
    always_comb begin
        o_we = '0;
        for (int i = 0; i < LANES; i++) begin
            o_we[i] = i_we[i] && (i_waddr[i*ADDR_W +: ADDR_W] != ADDR_W'(R0_ADDR));
            for (int j = i + 1; j < LANES; j++)
                if (i_we[j] && i_waddr[j*ADDR_W +: ADDR_W] == i_waddr[i*ADDR_W +: ADDR_W])
                    o_we[i] = 1'b0;
        end
    end
endmodule

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: MEM->WB stage with a 2-entry skid buffer, flush and write sanitisation
module wb_pipe_stage
    import wb_pipe_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_we,
    input  logic [LANES*ADDR_W-1:0] in_waddr,
    input  logic [LANES*DATA_W-1:0] in_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        wb_we,
    output logic [LANES*ADDR_W-1:0] wb_waddr,
    output logic [LANES*DATA_W-1:0] wb_wdata,
    output logic [1:0]              occupancy
);
    logic [LANES-1:0]        r_we    [2];
    logic [LANES*ADDR_W-1:0] r_waddr [2];
    logic [LANES*DATA_W-1:0] r_wdata [2];
    logic                    r_head, r_tail;
    logic [1:0]              r_count;
    logic [LANES-1:0]        w_we_san;
    logic                    w_run, w_push, w_pop;

    wb_lane_sanitize #(.LANES(LANES), .ADDR_W(ADDR_W)) u_san (
        .i_we   (in_we),
        .i_waddr(in_waddr),
        .o_we   (w_we_san)
    );

    assign w_run     = (rst != RST_ACTIVE);
    assign in_ready  = w_run && (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign occupancy = r_count;
    assign wb_we     = r_we[r_head] & {LANES{w_pop}};
    assign wb_waddr  = out_valid ? r_waddr[r_head] : '0;
    assign wb_wdata  = out_valid ? r_wdata[r_head] : '0;

    // Entry contents survive a flush; out_valid masks them until overwritten.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            r_we    <= '{default: '0};
            r_waddr <= '{default: '0};
            r_wdata <= '{default: '0};
        end else if (flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_we[r_tail]    <= w_we_san;
                r_waddr[r_tail] <= in_waddr;
                r_wdata[r_tail] <= in_wdata;
                r_tail          <= ~r_tail;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule
